// File: rtl/nios_onchip_mem_pkg.sv
// Shared types and helpers for the NIOS on-chip memory pipeline.
package nios_onchip_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Even parity: the stored bit makes the lane's total count of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/nios_onchip_mem_ram.sv
// Inferred single-port RAM with per-lane write enables and a registered read port.
module nios_onchip_mem_ram #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [LANES-1:0]         we_lane,
    input  logic [LANES*LANE_W-1:0]  wdata,
    input  logic                     re,
    output logic [LANES*LANE_W-1:0]  q
);

    logic [LANES-1:0][LANE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we_lane[i]) begin
                mem[addr][i] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Read register only loads on a read, so it holds the last word returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/nios_onchip_mem_pipe.sv
// Avalon-MM on-chip memory with optional zero-fill and 1/2-cycle read latency.
// Define NIOS_ONCHIP_MEM_PARITY_EN to store per-byte even parity and add parity_err.
module nios_onchip_mem_pipe
    import nios_onchip_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 10,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_PROTECT  = 1,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                debugaccess,
    input  logic                clken,
    input  logic                reset_req,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest
`ifdef NIOS_ONCHIP_MEM_PARITY_EN
    ,
    output logic                parity_err
`endif
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef NIOS_ONCHIP_MEM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam int LAT = (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                         (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : READ_LATENCY;

    mem_state_t           state;
    logic [ADDR_W-1:0]    ctr;
    logic                 accept, wr_en, rd_en;
    logic [ADDR_W-1:0]    ram_addr;
    logic [NB-1:0]        ram_we;
    logic [NB*LANE_W-1:0] ram_wdata, ram_q;
    logic                 vld_p0;
    logic [DATA_W-1:0]    rdata_p0;

    assign waitrequest = reset | reset_req | ~clken | (state == CLEAR);
    assign accept      = chipselect & (read | write) & ~waitrequest;
    assign wr_en       = accept & write & ((WRITE_PROTECT == 0) | debugaccess);
    // A simultaneous read and write is a write only.
    assign rd_en       = accept & read & ~write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            ctr   <= '0;
        end else if (state == CLEAR) begin
            ctr <= ctr + 1'b1;
            if (ctr == ADDR_W'(DEPTH - 1)) begin
                state <= READY;
            end
        end
    end

    always_comb begin
        ram_addr  = address;
        ram_we    = '0;
        ram_wdata = '0;
        if (state == CLEAR) begin
            ram_addr = ctr;
            ram_we   = '1;
        end else begin
            for (int i = 0; i < NB; i++) begin
                ram_we[i] = wr_en & byteenable[i];
`ifdef NIOS_ONCHIP_MEM_PARITY_EN
                ram_wdata[i*LANE_W +: LANE_W] = {byte_parity(writedata[i*8 +: 8]), writedata[i*8 +: 8]};
`else
                ram_wdata[i*LANE_W +: LANE_W] = writedata[i*8 +: 8];
`endif
            end
        end
    end

    nios_onchip_mem_ram #(
        .LANES  (NB),
        .LANE_W (LANE_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .addr    (ram_addr),
        .we_lane (ram_we),
        .wdata   (ram_wdata),
        .re      (rd_en),
        .q       (ram_q)
    );

    // Stage p0: RAM read register output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_en;
        end
    end

    always_comb begin
        rdata_p0 = '0;
        for (int i = 0; i < NB; i++) begin
            rdata_p0[i*8 +: 8] = ram_q[i*LANE_W +: 8];
        end
    end

    // Stage p1: optional output register
    generate
        if (LAT == 1) begin : g_lat1
            assign readdata      = rdata_p0;
            assign readdatavalid = vld_p0;
        end else begin : g_lat2
            logic              vld_p1;
            logic [DATA_W-1:0] rdata_p1;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_p1   <= 1'b0;
                    rdata_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        rdata_p1 <= rdata_p0;
                    end
                end
            end
            assign readdata      = rdata_p1;
            assign readdatavalid = vld_p1;
        end
    endgenerate

`ifdef NIOS_ONCHIP_MEM_PARITY_EN
    logic perr_p0;

    always_comb begin
        perr_p0 = 1'b0;
        for (int i = 0; i < NB; i++) begin
            perr_p0 = perr_p0 | (^ram_q[i*LANE_W +: LANE_W]);
        end
    end

    generate
        if (LAT == 1) begin : g_par1
            assign parity_err = vld_p0 & perr_p0;
        end else begin : g_par2
            logic perr_p1;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    perr_p1 <= 1'b0;
                end else begin
                    perr_p1 <= vld_p0 & perr_p0;
                end
            end
            assign parity_err = perr_p1;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_nios_onchip_mem_pipe.sv
// Self-checking bench: three configurations share one command bus, checked against a word-array model.
module tb_nios_onchip_mem_pipe;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect, read, write;
    logic [31:0]       writedata;
    logic              debugaccess, clken, reset_req;

    logic [31:0] rd_a, rd_l2, rd_c;
    logic        v_a, v_l2, v_c, w_a, w_l2, w_c;
`ifdef NIOS_ONCHIP_MEM_PARITY_EN
    logic        pe_a, pe_l2, pe_c;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [0:1023];

    always #5 clk = ~clk;

    nios_onchip_mem_pipe #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .debugaccess(debugaccess), .clken(clken), .reset_req(reset_req),
        .readdata(rd_a), .readdatavalid(v_a), .waitrequest(w_a)
`ifdef NIOS_ONCHIP_MEM_PARITY_EN
        , .parity_err(pe_a)
`endif
    );

    nios_onchip_mem_pipe #(.READ_LATENCY(2)) dut_l2 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .debugaccess(debugaccess), .clken(clken), .reset_req(reset_req),
        .readdata(rd_l2), .readdatavalid(v_l2), .waitrequest(w_l2)
`ifdef NIOS_ONCHIP_MEM_PARITY_EN
        , .parity_err(pe_l2)
`endif
    );

    nios_onchip_mem_pipe #(.ADDR_W(4), .CLEAR_ON_RESET(1)) dut_c (
        .clk(clk), .reset(reset), .address(address[3:0]), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .debugaccess(debugaccess), .clken(clken), .reset_req(reset_req),
        .readdata(rd_c), .readdatavalid(v_c), .waitrequest(w_c)
`ifdef NIOS_ONCHIP_MEM_PARITY_EN
        , .parity_err(pe_c)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    task automatic bus_write(input int addr, input logic [31:0] data, input logic [3:0] be,
                             input logic dbg);
        chipselect  = 1'b1; write = 1'b1; read = 1'b0;
        address     = ADDR_W'(addr);
        writedata   = data;
        byteenable  = be;
        debugaccess = dbg;
        tick();
        if (dbg) ref_mem[addr] = merge(ref_mem[addr], data, be);
        idle();
    endtask

    task automatic read_one(input int addr);
        chipselect = 1'b1; read = 1'b1; write = 1'b0;
        address    = ADDR_W'(addr);
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); clken = 1'b1; reset_req = 1'b0; debugaccess = 1'b1;
        address = '0; byteenable = '0; writedata = '0;
        repeat (3) tick();
        n_cmp++; if (v_a !== 1'b0 || v_l2 !== 1'b0 || v_c !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got a=%b l2=%b c=%b want 0", v_a, v_l2, v_c); end
        n_cmp++; if (rd_a !== 32'h0 || rd_l2 !== 32'h0 || rd_c !== 32'h0) begin
            n_err++; $display("FAIL reset_rdata: got %h %h %h want 0", rd_a, rd_l2, rd_c); end
        n_cmp++; if (w_a !== 1'b1 || w_l2 !== 1'b1 || w_c !== 1'b1) begin
            n_err++; $display("FAIL reset_wait: got %b %b %b want 1", w_a, w_l2, w_c); end
        reset = 1'b0;
        #1;
        n_cmp++; if (w_a !== 1'b0) begin
            n_err++; $display("FAIL ready_after_reset: waitrequest got %b want 0", w_a); end
    endtask

    task automatic test_clear(input string tag);
        int cnt = 0;
        idle();
        while (w_c === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
        n_cmp++; if (cnt != 16) begin
            n_err++; $display("FAIL clear_cycles_%s: got %0d want 16", tag, cnt); end
        for (int i = 0; i < 16; i++) begin
            chipselect = 1'b1; read = 1'b1; write = 1'b0; address = ADDR_W'(i);
            tick();
            n_cmp++; if (v_c !== 1'b1 || rd_c !== 32'h0) begin
                n_err++; $display("FAIL clear_read_%s[%0d]: got v=%b d=%h want v=1 d=0", tag, i, v_c, rd_c); end
        end
        idle();
        tick();
        n_cmp++; if (v_c !== 1'b0) begin
            n_err++; $display("FAIL clear_drain_%s: valid got %b want 0", tag, v_c); end
    endtask

    task automatic test_basic();
        bus_write(5, 32'hDEADBEEF, 4'hF, 1'b1);
        n_cmp++; if (v_a !== 1'b0) begin
            n_err++; $display("FAIL basic_no_valid_on_write: got %b want 0", v_a); end
        read_one(5);
        n_cmp++; if (v_a !== 1'b1 || rd_a !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL basic_read_l1: got v=%b d=%h want v=1 d=deadbeef", v_a, rd_a); end
        n_cmp++; if (v_l2 !== 1'b0) begin
            n_err++; $display("FAIL basic_l2_early: got %b want 0", v_l2); end
        tick();
        n_cmp++; if (v_a !== 1'b0 || rd_a !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL basic_pulse_hold: got v=%b d=%h want v=0 d=deadbeef", v_a, rd_a); end
        n_cmp++; if (v_l2 !== 1'b1 || rd_l2 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL basic_read_l2: got v=%b d=%h want v=1 d=deadbeef", v_l2, rd_l2); end
    endtask

    task automatic test_byteenable();
        bus_write(5, 32'h11223344, 4'h5, 1'b1);
        read_one(5);
        n_cmp++; if (v_a !== 1'b1 || rd_a !== 32'hDE22BE44) begin
            n_err++; $display("FAIL byteenable: got v=%b d=%h want v=1 d=de22be44", v_a, rd_a); end
    endtask

    task automatic test_protect();
        bus_write(5, 32'h0, 4'hF, 1'b0);
        read_one(5);
        n_cmp++; if (v_a !== 1'b1 || rd_a !== 32'hDE22BE44) begin
            n_err++; $display("FAIL write_protect: got v=%b d=%h want v=1 d=de22be44", v_a, rd_a); end
    endtask

    task automatic test_lat2_clken();
        logic [31:0] expq[$];
        int          dueq[$];
        int          pulses = 0;
        for (int i = 0; i < 3; i++) bus_write(i, $urandom, 4'hF, 1'b1);
        for (int c = 0; c < 8; c++) begin
            clken = (c != 2);
            if (c < 4) begin
                chipselect = 1'b1; read = 1'b1; write = 1'b0;
                address = ADDR_W'((c < 2) ? c : 2);
            end else begin
                idle();
            end
            #1;
            if (c == 2) begin
                n_cmp++; if (w_l2 !== 1'b1) begin
                    n_err++; $display("FAIL clken_wait: got %b want 1", w_l2); end
            end
            if (c < 4 && c != 2) begin
                expq.push_back(ref_mem[address]);
                dueq.push_back(c + 1);
            end
            tick();
            if (v_l2 === 1'b1) begin
                pulses++;
                n_cmp++;
                if (expq.size() == 0) begin
                    n_err++; $display("FAIL l2_extra_pulse: cycle %0d got pulse want none", c);
                end else begin
                    logic [31:0] e;
                    int          d;
                    e = expq.pop_front();
                    d = dueq.pop_front();
                    if (rd_l2 !== e || d != c) begin
                        n_err++; $display("FAIL l2_order: cycle %0d got %h want %h at cycle %0d", c, rd_l2, e, d);
                    end
                end
            end
        end
        clken = 1'b1;
        n_cmp++; if (pulses != 3) begin
            n_err++; $display("FAIL l2_pulse_count: got %0d want 3", pulses); end
    endtask

    task automatic test_back_to_back();
        logic        pv = 1'b0, cur_v, exp_wait, acc, have_a = 1'b0, have_l2 = 1'b0;
        logic [31:0] pd = '0, cur_d, last_a = '0, last_l2 = '0;
        for (int i = 0; i < 16; i++) bus_write(i, $urandom, 4'hF, 1'b1);
        for (int c = 0; c < 300; c++) begin
            chipselect  = ($urandom % 8) != 0;
            read        = $urandom % 2;
            write       = ($urandom % 3) == 0;
            address     = ADDR_W'($urandom % 16);
            byteenable  = 4'($urandom);
            writedata   = $urandom;
            debugaccess = ($urandom % 4) != 0;
            clken       = ($urandom % 10) != 0;
            reset_req   = ($urandom % 16) == 0;
            #1;
            exp_wait = ~clken | reset_req;
            n_cmp++; if (w_a !== exp_wait) begin
                n_err++; $display("FAIL rnd_wait[%0d]: got %b want %b", c, w_a, exp_wait); end
            acc   = chipselect & (read | write) & ~exp_wait;
            cur_v = acc & read & ~write;
            cur_d = ref_mem[address];
            if (acc && write && debugaccess)
                ref_mem[address] = merge(ref_mem[address], writedata, byteenable);
            tick();
            n_cmp++;
            if (v_a !== cur_v || (cur_v && rd_a !== cur_d) || (!cur_v && have_a && rd_a !== last_a)) begin
                n_err++; $display("FAIL rnd_l1[%0d]: got v=%b d=%h want v=%b d=%h", c, v_a, rd_a, cur_v,
                                  cur_v ? cur_d : last_a);
            end
            n_cmp++;
            if (v_l2 !== pv || (pv && rd_l2 !== pd) || (!pv && have_l2 && rd_l2 !== last_l2)) begin
                n_err++; $display("FAIL rnd_l2[%0d]: got v=%b d=%h want v=%b d=%h", c, v_l2, rd_l2, pv,
                                  pv ? pd : last_l2);
            end
            if (cur_v) begin last_a = cur_d; have_a = 1'b1; end
            if (pv) begin last_l2 = pd; have_l2 = 1'b1; end
            pv = cur_v;
            pd = cur_d;
        end
        idle(); clken = 1'b1; reset_req = 1'b0; debugaccess = 1'b1;
        tick();
        n_cmp++; if (v_l2 !== pv || (pv && rd_l2 !== pd)) begin
            n_err++; $display("FAIL rnd_l2_drain: got v=%b d=%h want v=%b d=%h", v_l2, rd_l2, pv, pd); end
    endtask

    task automatic test_reset_mid();
        read_one(3);
        reset = 1'b1;
        #1;
        n_cmp++; if (v_a !== 1'b0 || v_l2 !== 1'b0 || rd_a !== 32'h0 || rd_l2 !== 32'h0) begin
            n_err++; $display("FAIL reset_midread: got va=%b vl2=%b da=%h dl2=%h want 0", v_a, v_l2, rd_a, rd_l2); end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (v_l2 !== 1'b0 || v_a !== 1'b0) begin
            n_err++; $display("FAIL reset_discard: got va=%b vl2=%b want 0", v_a, v_l2); end
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        test_clear("restart");
        for (int i = 0; i < 16; i++) begin
            read_one(i);
            n_cmp++; if (v_a !== 1'b1 || rd_a !== ref_mem[i]) begin
                n_err++; $display("FAIL retain[%0d]: got v=%b d=%h want v=1 d=%h", i, v_a, rd_a, ref_mem[i]); end
        end
    endtask

`ifdef NIOS_ONCHIP_MEM_PARITY_EN
    task automatic test_parity();
        bus_write(7, $urandom, 4'hF, 1'b1);
        read_one(7);
        n_cmp++; if (v_a !== 1'b1 || pe_a !== 1'b0) begin
            n_err++; $display("FAIL parity_clean: got v=%b pe=%b want v=1 pe=0", v_a, pe_a); end
        dut_a.u_ram.mem[7][0][0] = ~dut_a.u_ram.mem[7][0][0];
        read_one(7);
        n_cmp++; if (v_a !== 1'b1 || pe_a !== 1'b1) begin
            n_err++; $display("FAIL parity_flip: got v=%b pe=%b want v=1 pe=1", v_a, pe_a); end
        tick();
        n_cmp++; if (pe_a !== 1'b0) begin
            n_err++; $display("FAIL parity_pulse: got %b want 0", pe_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_clear("initial");
        test_basic();
        test_byteenable();
        test_protect();
        test_lat2_clken();
        test_back_to_back();
        test_reset_mid();
`ifdef NIOS_ONCHIP_MEM_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
